// File: rtl/fork_oehb_dataless.sv
// Dataless eager fork behind a registered input slot: one control token in,
// one copy delivered independently to each of OUTPUTS consumers.

module fork_oehb_dataless_lane (
    input  logic clk,
    input  logic rst,
    input  logic i_buf_valid,
    input  logic i_fire,
    input  logic i_ready,
    output logic o_valid,
    output logic o_done
);
    logic r_sent;

    assign o_valid = i_buf_valid & ~r_sent;
    assign o_done  = r_sent | i_ready;

    // A copy taken early is remembered until every lane has its copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    r_sent <= 1'b0;
        else if (i_fire)             r_sent <= 1'b0;
        else if (o_valid & i_ready)  r_sent <= 1'b1;
    end
endmodule

module fork_oehb_dataless #(
    parameter int OUTPUTS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ins_valid,
    output logic               ins_ready,
    output logic [OUTPUTS-1:0] outs_valid,
    input  logic [OUTPUTS-1:0] outs_ready
);
    logic               r_buf_valid;
    logic [OUTPUTS-1:0] w_done;
    logic               w_fire;
    logic               w_acc;

    assign w_fire    = r_buf_valid & (&w_done);
    // Refill in the same cycle the last copy leaves, so streaming runs at 1/cycle.
    assign ins_ready = ~r_buf_valid | w_fire;
    assign w_acc     = ins_valid & ins_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_buf_valid <= 1'b0;
        else if (w_acc)  r_buf_valid <= 1'b1;
        else if (w_fire) r_buf_valid <= 1'b0;
    end

    for (genvar g = 0; g < OUTPUTS; g++) begin : g_lane
        fork_oehb_dataless_lane u_lane (
            .clk         (clk),
            .rst         (rst),
            .i_buf_valid (r_buf_valid),
            .i_fire      (w_fire),
            .i_ready     (outs_ready[g]),
            .o_valid     (outs_valid[g]),
            .o_done      (w_done[g])
        );
    end
endmodule
